mcycle_controller: RTL and testbench
====================================

# mcycle_controller

Multicycle control unit for the 16-bit CPU. It sits directly upstream of the datapath and drives every datapath control strobe (PC write, IR load, ALU select, register write). It decodes the instruction the datapath returns on `ir` and sequences fetch, decode, execute, memory and write-back states. It owns the memory request/ready handshake and includes a wait-state watchdog.

## Interface
Parameters:
- `WIDTH`, 16: instruction width.
- `WAIT_MAX`, 15: maximum wait cycles tolerated per memory access before fault.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ir`  in  WIDTH  instruction register contents from the datapath.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write_en`  out  1  PC register write enable.
- `pc_src_sel`  out  1  next-PC select: 0 = PC+2, 1 = ALU result.
- `alu_src`  out  1  ALU B select: 0 = register, 1 = sign-extended immediate.
- `reg_dst`  out  1  write address select: 1 = ir[3:0], 0 = ir[7:4].
- `reg_write`  out  1  register file write enable.
- `ir_load`  out  1  IR load enable.
- `alu_op`  out  4  ALU operation.
- `iord`  out  1  memory address source: 0 = PC, 1 = ALU result.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `instr_done`  out  1  one-cycle pulse when an instruction retires.
- `halted`  out  1  level, HALT executed.
- `fault`  out  1  level, memory watchdog expired.

## Operation
- Opcode is `ir[15:12]`:
  - 0x0–0x7 are register ALU operations: `alu_op={0,op[2:0]}`, `alu_src=0`, `reg_dst=1`.
  - 0x8–0xB are immediate ALU operations: `alu_op={00,op[1:0]}`, `alu_src=1`, `reg_dst=0`.
  - 0xC is LOAD, 0xD is STORE, 0xE is JUMP and 0xF is HALT.
  - LOAD, STORE and JUMP compute their address with `alu_op=0x0` (ADD) and `alu_src=1`.
- States: IDLE, FETCH, DECODE, EXEC, WB, MEMADR, MEMRD, MEMWB, MEMWR, JUMP, HALT, FAULT.
- Transitions:
  - IDLE→FETCH unconditionally.
  - FETCH→DECODE on `mem_ready`.
  - DECODE→EXEC for ALU opcodes, then EXEC→WB→FETCH.
  - DECODE→MEMADR for 0xC/0xD. MEMADR→MEMRD for LOAD, then MEMRD→MEMWB (on `mem_ready`)→FETCH. MEMADR→MEMWR for STORE, then MEMWR→FETCH (on `mem_ready`).
  - DECODE→JUMP→FETCH for 0xE.
  - DECODE→HALT for 0xF.
  - HALT and FAULT are terminal until reset.
- Outputs:
  - FETCH: `mem_req=1`, `iord=0`. On the `mem_ready` cycle only, also `ir_load=1` and `pc_write_en=1` with `pc_src_sel=0`.
  - EXEC: ALU controls per opcode.
  - WB: ALU controls held, `reg_write=1`, `instr_done=1`.
  - MEMADR: address ALU controls.
  - MEMRD: `mem_req=1`, `iord=1`, `mem_we=0`.
  - MEMWB: `reg_write=1`, `reg_dst=0`, `instr_done=1`.
  - MEMWR: `mem_req=1`, `iord=1`, `mem_we=1`. On the `mem_ready` cycle, also `instr_done=1`.
  - JUMP: address ALU controls, `pc_src_sel=1`, `pc_write_en=1`, `instr_done=1`.
  - HALT: `halted=1`.
  - FAULT: `fault=1`.
- Every output not listed for a state is 0.
- Watchdog:
  - The wait counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle the state holds with `mem_ready=0`.
  - `mem_ready=0` while the counter equals `WAIT_MAX` sends the FSM to FAULT next cycle, so a memory state lasts at most `WAIT_MAX+1` cycles.
  - `mem_ready=1` on that same cycle wins and the FSM proceeds normally.
- `mem_ready` outside the memory states is ignored.

## Timing
- Reset (`reset=0`): the FSM enters IDLE asynchronously, the counter clears, and all outputs are 0. Reset mid-access drops `mem_req` immediately.
- First `mem_req` is asserted in the second cycle after reset deassertion (IDLE lasts exactly one cycle).
- Latency with zero wait states, FETCH through retire inclusive:
  - ALU: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - JUMP: 3 cycles.
  - Each wait cycle adds one.
- Outputs are registered-state decodes. `ir_load`, `pc_write_en` (FETCH only) and `instr_done` in MEMWR are Mealy terms on `mem_ready`.
- `instr_done` is asserted at most once per instruction, never in HALT or FAULT.

## Structure
- Package `control_pkg`: state enum, opcode constants (OP_LOAD=0xC, OP_STORE=0xD, OP_JUMP=0xE, OP_HALT=0xF), ALU_ADD=0x0.
- Sub-module `wait_timer` (parameter `WAIT_MAX`):
  - Inputs: `clk`, `reset`, `clear`, `busy`, `mem_ready`.
  - Output: `expire`.
  - Counter width is `$clog2(WAIT_MAX+1)`, minimum 1.
- FSM and output decode stay in `mcycle_controller`.

## Test plan
- **Register ALU:** `ir=0x3125`, `mem_ready` held 1.
  - Required: `ir_load` and `pc_write_en` in cycle 2 after reset release, EXEC `alu_op=0x3 alu_src=0`.
  - Required: WB `reg_write=1 reg_dst=1 instr_done=1`, back in FETCH at cycle 6.
- **LOAD with waits:** `ir=0xC204`, `mem_ready` low for 2 cycles in MEMRD.
  - Required: MEMRD lasts 3 cycles with `iord=1 mem_we=0`, then MEMWB `reg_write=1`; total 7 cycles.
- **Watchdog expiry:** `WAIT_MAX=3`, `mem_ready` stuck 0 in FETCH.
  - Required: `mem_req` high for exactly 4 cycles, then `fault=1` and all strobes 0 until reset.
- **JUMP:** `ir=0xE010`.
  - Required: JUMP state `pc_src_sel=1 pc_write_en=1 alu_src=1 alu_op=0x0 instr_done=1`, FETCH next cycle.
- **HALT:** `ir=0xF000`.
  - Required: `halted=1` persists for 20 cycles with `mem_req=0`; `reset` pulse low returns to IDLE then FETCH.
- **Reset mid-store:** `ir=0xD104`, `reset` asserted during MEMWR with `mem_req=1 mem_we=1`.
  - Required: both drop in the same cycle, no `instr_done`.

Source files
------------

// File: rtl/mcycle_controller_pkg.sv
// Shared types and constants for the multicycle control unit: FSM states,
// reserved opcodes and the ALU operation decode helpers.
package control_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_JUMP,
        ST_HALT,
        ST_FAULT
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'hC;
    localparam logic [3:0] OP_STORE = 4'hD;
    localparam logic [3:0] OP_JUMP  = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;
    localparam logic [3:0] ALU_ADD  = 4'h0;

    // Opcodes 0x0-0xB are ALU operations; 0x8-0xB only carry a 2-bit function.
    function automatic logic is_alu(input logic [3:0] op);
        return op < OP_LOAD;
    endfunction

    function automatic logic [3:0] alu_op_of(input logic [3:0] op);
        return op[3] ? {2'b00, op[1:0]} : {1'b0, op[2:0]};
    endfunction

endpackage

// File: rtl/mcycle_controller_if.sv
// Control/handshake bundle between the control unit and the datapath/memory.
interface mcycle_controller_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] ir;
    logic             mem_ready;
    logic             pc_write_en;
    logic             pc_src_sel;
    logic             alu_src;
    logic             reg_dst;
    logic             reg_write;
    logic             ir_load;
    logic [3:0]       alu_op;
    logic             iord;
    logic             mem_req;
    logic             mem_we;
    logic             instr_done;
    logic             halted;
    logic             fault;

    modport master (
        input  ir, mem_ready,
        output pc_write_en, pc_src_sel, alu_src, reg_dst, reg_write, ir_load,
               alu_op, iord, mem_req, mem_we, instr_done, halted, fault
    );

    modport slave (
        output ir, mem_ready,
        input  pc_write_en, pc_src_sel, alu_src, reg_dst, reg_write, ir_load,
               alu_op, iord, mem_req, mem_we, instr_done, halted, fault
    );
endinterface

// File: rtl/mcycle_controller_wait_timer.sv
// Memory wait-state watchdog: counts stalled cycles of one access and flags
// expiry when a stall would exceed WAIT_MAX.
module wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic busy,
    input  logic mem_ready,
    output logic expire
);
    localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] MAX_C = CW'(WAIT_MAX);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (busy && !mem_ready && (r_count != MAX_C)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // A ready on the final allowed cycle still completes the access.
    assign expire = busy && !mem_ready && (r_count == MAX_C);

endmodule

// File: rtl/mcycle_controller.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/write-back
// and decodes the datapath strobes from the registered state.
module mcycle_controller
    import control_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    mcycle_controller_if.master  bus
);
    state_t     r_state;
    logic [3:0] w_op;
    logic       w_busy;
    logic       w_clear;
    logic       w_expire;
    logic       w_unused_ir;

    assign w_op        = bus.ir[WIDTH-1 -: 4];
    assign w_unused_ir = ^bus.ir[WIDTH-5:0];

    // Every memory state is left on mem_ready, so clearing on completion
    // guarantees a zero count on entry to the next access.
    assign w_busy  = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
    assign w_clear = !w_busy || bus.mem_ready;

    wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_clear),
        .busy      (w_busy),
        .mem_ready (bus.mem_ready),
        .expire    (w_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (bus.mem_ready)  r_state <= ST_DECODE;
                    else if (w_expire)  r_state <= ST_FAULT;
                end
                ST_DECODE: begin
                    if (is_alu(w_op))                              r_state <= ST_EXEC;
                    else if ((w_op == OP_LOAD) || (w_op == OP_STORE)) r_state <= ST_MEMADR;
                    else if (w_op == OP_JUMP)                      r_state <= ST_JUMP;
                    else                                           r_state <= ST_HALT;
                end
                ST_EXEC:   r_state <= ST_WB;
                ST_WB:     r_state <= ST_FETCH;
                ST_MEMADR: r_state <= (w_op == OP_STORE) ? ST_MEMWR : ST_MEMRD;
                ST_MEMRD: begin
                    if (bus.mem_ready)  r_state <= ST_MEMWB;
                    else if (w_expire)  r_state <= ST_FAULT;
                end
                ST_MEMWB:  r_state <= ST_FETCH;
                ST_MEMWR: begin
                    if (bus.mem_ready)  r_state <= ST_FETCH;
                    else if (w_expire)  r_state <= ST_FAULT;
                end
                ST_JUMP:   r_state <= ST_FETCH;
                ST_HALT:   r_state <= ST_HALT;
                ST_FAULT:  r_state <= ST_FAULT;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.pc_write_en = 1'b0;
        bus.pc_src_sel  = 1'b0;
        bus.alu_src     = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.reg_write   = 1'b0;
        bus.ir_load     = 1'b0;
        bus.alu_op      = ALU_ADD;
        bus.iord        = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.instr_done  = 1'b0;
        bus.halted      = 1'b0;
        bus.fault       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                bus.mem_req     = 1'b1;
                bus.ir_load     = bus.mem_ready;
                bus.pc_write_en = bus.mem_ready;
            end
            ST_EXEC, ST_WB: begin
                bus.alu_op     = alu_op_of(w_op);
                bus.alu_src    = w_op[3];
                bus.reg_dst    = !w_op[3];
                bus.reg_write  = (r_state == ST_WB);
                bus.instr_done = (r_state == ST_WB);
            end
            ST_MEMADR: begin
                bus.alu_src = 1'b1;
            end
            ST_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            ST_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            ST_MEMWR: begin
                bus.mem_req    = 1'b1;
                bus.iord       = 1'b1;
                bus.mem_we     = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            ST_JUMP: begin
                bus.alu_src     = 1'b1;
                bus.pc_src_sel  = 1'b1;
                bus.pc_write_en = 1'b1;
                bus.instr_done  = 1'b1;
            end
            ST_HALT:  bus.halted = 1'b1;
            ST_FAULT: bus.fault  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mcycle_controller.sv
// Randomized scoreboard bench for mcycle_controller: the driver expands each
// instruction into expected per-cycle strobes, the monitor checks them.
module tb_mcycle_controller;

    localparam int WIDTH    = 16;
    localparam int WAIT_MAX = 3;

    typedef struct packed {
        logic       pc_write_en;
        logic       pc_src_sel;
        logic       alu_src;
        logic       reg_dst;
        logic       reg_write;
        logic       ir_load;
        logic [3:0] alu_op;
        logic       iord;
        logic       mem_req;
        logic       mem_we;
        logic       instr_done;
        logic       halted;
        logic       fault;
    } outs_t;

    logic        clk;
    logic        reset;
    logic        rst_v;
    logic [15:0] cur_ir;
    int          n_cmp;
    int          n_err;
    int          cyc;
    outs_t       exp_q[$];
    string       tag_q[$];

    mcycle_controller_if #(.WIDTH(WIDTH)) bus ();

    mcycle_controller #(
        .WIDTH    (WIDTH),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: one expected strobe set per cycle, sampled mid-cycle.
    initial begin
        outs_t a;
        outs_t e;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a.pc_write_en = bus.pc_write_en;
                a.pc_src_sel  = bus.pc_src_sel;
                a.alu_src     = bus.alu_src;
                a.reg_dst     = bus.reg_dst;
                a.reg_write   = bus.reg_write;
                a.ir_load     = bus.ir_load;
                a.alu_op      = bus.alu_op;
                a.iord        = bus.iord;
                a.mem_req     = bus.mem_req;
                a.mem_we      = bus.mem_we;
                a.instr_done  = bus.instr_done;
                a.halted      = bus.halted;
                a.fault       = bus.fault;
                n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL %s cycle=%0d ir=%h got=%h exp=%h", t, cyc, cur_ir, a, e);
                end
            end
        end
    end

    task automatic step(input logic rdy, input outs_t e, input string tag);
        @(posedge clk);
        #1;
        reset         = rst_v;
        bus.mem_ready = rdy;
        bus.ir        = cur_ir;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset();
        rst_v = 1'b0;
        step(1'b0, '0, "reset");
        step(1'b1, '0, "reset");
        rst_v = 1'b1;
        step(1'b1, '0, "idle");
    endtask

    task automatic fault_tail();
        outs_t e;
        e = '0;
        e.fault = 1'b1;
        for (int i = 0; i < 3; i++) step(rnd_bit(), e, "fault");
        do_reset();
    endtask

    // One memory access: waits beyond WAIT_MAX end in the watchdog firing.
    task automatic mem_phase(input int waits, input outs_t base, input outs_t extra,
                             input string tag, output bit flt);
        flt = 1'b0;
        if (waits > WAIT_MAX) begin
            for (int i = 0; i <= WAIT_MAX; i++) step(1'b0, base, tag);
            flt = 1'b1;
        end else begin
            for (int i = 0; i <= waits; i++) begin
                if (i == waits) step(1'b1, outs_t'(base | extra), tag);
                else            step(1'b0, base, tag);
            end
        end
    endtask

    task automatic fetch(input int fw, output bit flt);
        outs_t b;
        outs_t x;
        b = '0;
        b.mem_req = 1'b1;
        x = '0;
        x.ir_load     = 1'b1;
        x.pc_write_en = 1'b1;
        mem_phase(fw, b, x, "fetch", flt);
    endtask

    task automatic run_instr(input logic [15:0] ir_v, input int fw, input int mw);
        outs_t b;
        outs_t x;
        bit    flt;
        int    op;
        op = int'(ir_v[15:12]);
        $display("instr ir=%h fetch_waits=%0d mem_waits=%0d", ir_v, fw, mw);
        cur_ir = ir_v;
        fetch(fw, flt);
        if (flt) begin
            fault_tail();
        end else begin
            step(rnd_bit(), '0, "decode");
            b = '0;
            if (op < 12) begin
                b.alu_op  = (op < 8) ? 4'(op % 8) : 4'(op - 8);
                b.alu_src = (op >= 8);
                b.reg_dst = (op < 8);
                step(rnd_bit(), b, "exec");
                b.reg_write  = 1'b1;
                b.instr_done = 1'b1;
                step(rnd_bit(), b, "wb");
            end else if (op == 12 || op == 13) begin
                b.alu_src = 1'b1;
                step(rnd_bit(), b, "memadr");
                b = '0;
                b.mem_req = 1'b1;
                b.iord    = 1'b1;
                b.mem_we  = (op == 13);
                x = '0;
                x.instr_done = (op == 13);
                mem_phase(mw, b, x, (op == 13) ? "memwr" : "memrd", flt);
                if (flt) begin
                    fault_tail();
                end else if (op == 12) begin
                    b = '0;
                    b.reg_write  = 1'b1;
                    b.instr_done = 1'b1;
                    step(rnd_bit(), b, "memwb");
                end
            end else if (op == 14) begin
                b.alu_src     = 1'b1;
                b.pc_src_sel  = 1'b1;
                b.pc_write_en = 1'b1;
                b.instr_done  = 1'b1;
                step(rnd_bit(), b, "jump");
            end else begin
                b.halted = 1'b1;
                for (int i = 0; i < 20; i++) step(rnd_bit(), b, "halt");
                do_reset();
            end
        end
    endtask

    initial begin
        outs_t b;
        bit    flt;
        int    op;
        int    fw;
        int    mw;
        n_cmp         = 0;
        n_err         = 0;
        rst_v         = 1'b0;
        reset         = 1'b0;
        cur_ir        = '0;
        bus.ir        = '0;
        bus.mem_ready = 1'b0;
        do_reset();

        run_instr(16'h3125, 0, 0);
        run_instr(16'hC204, 0, 2);
        run_instr(16'hE010, 0, 0);
        run_instr(16'h9A31, 1, 0);
        run_instr(16'hD104, 0, WAIT_MAX);
        run_instr(16'h3125, WAIT_MAX + 1, 0);
        run_instr(16'hC204, 0, WAIT_MAX + 1);
        run_instr(16'hF000, 0, 0);

        // Reset asserted while a store is waiting on memory.
        $display("instr ir=d104 reset during memwr");
        cur_ir = 16'hD104;
        fetch(0, flt);
        step(1'b1, '0, "decode");
        b = '0;
        b.alu_src = 1'b1;
        step(1'b1, b, "memadr");
        b = '0;
        b.mem_req = 1'b1;
        b.iord    = 1'b1;
        b.mem_we  = 1'b1;
        step(1'b0, b, "memwr");
        rst_v = 1'b0;
        step(1'b1, '0, "rst_midstore");
        step(1'b1, '0, "reset");
        rst_v = 1'b1;
        step(1'b1, '0, "idle");

        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 15);
            fw = ($urandom_range(0, 24) == 0) ? WAIT_MAX + 1 : $urandom_range(0, WAIT_MAX);
            mw = ($urandom_range(0, 12) == 0) ? WAIT_MAX + 1 : $urandom_range(0, WAIT_MAX);
            run_instr({4'(op), 12'($urandom_range(0, 4095))}, fw, mw);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
